sync_fifo_flags: RTL

//  Single-clock, parametrised FIFO: the synchronous successor to our dual-clock FIFO, for buffering inside one clock domain.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 35 +++
 rtl/sync_fifo_flags.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: address-width helper and the status flag bundle.
// Both the synchronous and the dual-clock FIFO use this package.
package fifo_pkg;

    // Number of address bits needed to index a FIFO of 'depth' entries.
    // The result is never less than 1.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Registered occupancy flags.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage with one synchronous write port and one registered
// read port. The storage array and the read register have no reset, so the
// tools are free to map them onto block RAM.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write the array and register the read word; the read register holds its value when idle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with an occupancy count, almost-full and almost-empty
// thresholds, sticky overflow/underflow flags and a read-data-valid strobe.
// All flags are registered but are computed from the next count, so they
// change on the same edge as the count.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_EN,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_EN,
    output logic [WIDTH-1:0]         data_out,
    output logic                     Dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    // Reject illegal parameter sets while the design is being elaborated.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of 2 and at least 2");
    end
    if (!((AE_LEVEL >= 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $error("sync_fifo_flags: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    // Pointers carry one extra wrap bit; the low ADDR_W bits address the array.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_status_t     status_q, status_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             dout_valid_q, dout_valid_d;
    // Set by the first accepted read after reset. Until then data_out is
    // forced to zero, because the RAM read register itself is never reset.
    logic             data_seen_q, data_seen_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rd_data;

    // Accept decisions, next pointers, next count and the flags derived from that next count.
    always_comb begin
        // Acceptance uses only the registered flags. A slot freed by a read
        // therefore cannot be refilled in the same cycle, and an empty FIFO
        // never passes a word straight through to the output.
        wr_acc       = wr_EN && !status_q.full;
        rd_acc       = rd_EN && !status_q.empty;

        wr_ptr_d     = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d     = rd_ptr_q + PTR_W'(rd_acc);
        count_d      = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

        status_d.full         = (count_d == CNT_W'(DEPTH));
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= CNT_W'(AF_LEVEL));
        status_d.almost_empty = (count_d <= CNT_W'(AE_LEVEL));

        // Error flags are sticky. When a new error and err_clr arrive in the
        // same cycle, the new error wins.
        overflow_d   = (wr_EN && status_q.full)  || (overflow_q  && !err_clr);
        underflow_d  = (rd_EN && status_q.empty) || (underflow_q && !err_clr);

        dout_valid_d = rd_acc;
        data_seen_d  = data_seen_q || rd_acc;
    end

    // State registers: asynchronous reset, released synchronously by the reset source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            status_q     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            data_seen_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            status_q     <= status_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            dout_valid_q <= dout_valid_d;
            data_seen_q  <= data_seen_d;
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (mem_rd_data)
    );

    assign data_out     = data_seen_q ? mem_rd_data : '0;
    assign Dout_valid   = dout_valid_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
